// File: rtl/mac_result_collector_pkg.sv
// Shared MAC constants: default datapath widths and the collector FSM encoding.
package mac_result_collector_pkg;

    localparam int unsigned MAC_ACC_RES_W = 25;
    localparam int unsigned MAC_IDX_W     = 16;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mac_result_collector_fifo.sv
// ResultFifo2: two-entry valid/ready FIFO holding captured window results.
module ResultFifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ready_o,
    output logic             pop_valid_o,
    output logic [WIDTH-1:0] pop_data_o,
    input  logic             pop_ready_i
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign pop_valid_o  = (count_q != 2'd0);
    assign pop_data_o   = mem_q[rd_ptr_q];
    assign do_pop       = pop_valid_o && pop_ready_i;
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign push_ready_o = (count_q != 2'd2) || do_pop;
    assign do_push      = push_valid_i && push_ready_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// Counts MAC strobes per window, captures the accumulated result with a threshold
// flag and window index, clears the MAC, and buffers results for a ready/valid sink.
module mac_result_collector
    import mac_result_collector_pkg::*;
#(
    parameter int unsigned bitwidthAccRes = MAC_ACC_RES_W,
    parameter int unsigned AccCycles      = 400,
    parameter int unsigned bitwidthIdx    = MAC_IDX_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      newData,
    input  logic [bitwidthAccRes-1:0] AccResult,
    input  logic [bitwidthAccRes-1:0] threshold,
    input  logic                      outReady,
    output logic                      accClear,
    output logic                      outValid,
    output logic [bitwidthAccRes-1:0] outData,
    output logic                      outAbove,
    output logic [bitwidthIdx-1:0]    outIdx,
    output logic                      dropErr,
    output logic                      seqErr
);

    localparam int unsigned CNT_W   = (AccCycles > 1) ? $clog2(AccCycles) : 1;
    localparam int unsigned ENTRY_W = bitwidthAccRes + bitwidthIdx + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AccCycles - 1);

    mac_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [bitwidthIdx-1:0] idx_q, idx_d;
    logic                   dropErr_q, dropErr_d;
    logic                   seqErr_q, seqErr_d;

    logic               push_valid;
    logic               push_ready;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] pop_data;

    assign push_data = {(AccResult >= threshold), idx_q, AccResult};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        dropErr_d  = dropErr_q;
        seqErr_d   = seqErr_q;
        accClear   = 1'b0;
        push_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                if (newData) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                state_d = CAPTURE;
                if (newData) begin
                    seqErr_d = 1'b1;
                end
            end
            CAPTURE: begin
                accClear   = 1'b1;
                push_valid = 1'b1;
                idx_d      = idx_q + 1'b1;
                state_d    = ACCUM;
                if (newData) begin
                    seqErr_d = 1'b1;
                end
                if (!push_ready) begin
                    dropErr_d = 1'b1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            idx_q     <= '0;
            dropErr_q <= 1'b0;
            seqErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            dropErr_q <= dropErr_d;
            seqErr_q  <= seqErr_d;
        end
    end

    ResultFifo2 #(
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_valid_i(push_valid),
        .push_data_i (push_data),
        .push_ready_o(push_ready),
        .pop_valid_o (outValid),
        .pop_data_o  (pop_data),
        .pop_ready_i (outReady)
    );

    assign outData  = pop_data[bitwidthAccRes-1:0];
    assign outIdx   = pop_data[bitwidthAccRes +: bitwidthIdx];
    assign outAbove = pop_data[ENTRY_W-1];
    assign dropErr  = dropErr_q;
    assign seqErr   = seqErr_q;

endmodule

// File: tb/tb_mac_result_collector.sv
// Randomized bench for mac_result_collector against a queue-based window model.
module tb_mac_result_collector;

    localparam int unsigned AW = 25;
    localparam int unsigned AC = 4;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          newData = 1'b0;
    logic [AW-1:0] AccResult = '0;
    logic [AW-1:0] threshold = '0;
    logic          outReady = 1'b0;
    logic          accClear, outValid, outAbove, dropErr, seqErr;
    logic [AW-1:0] outData;
    logic [IW-1:0] outIdx;

    mac_result_collector #(
        .bitwidthAccRes(AW),
        .AccCycles     (AC),
        .bitwidthIdx   (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .newData  (newData),
        .AccResult(AccResult),
        .threshold(threshold),
        .outReady (outReady),
        .accClear (accClear),
        .outValid (outValid),
        .outData  (outData),
        .outAbove (outAbove),
        .outIdx   (outIdx),
        .dropErr  (dropErr),
        .seqErr   (seqErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] d;
        logic          a;
        int unsigned   idx;
    } ent_t;

    // Model: strobes counted in the current window, and cycles since the window
    // closed (0 = accumulating, 1 = settle cycle, 2 = capture cycle).
    ent_t        q[$];
    int unsigned m_cnt, m_after, m_idx;
    logic        m_drop, m_seq;
    int unsigned n_vec = 0;
    int unsigned n_miscmp = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_after = 0; m_idx = 0; m_drop = 1'b0; m_seq = 1'b0;
    endtask

    task automatic model_step(input logic nd, input logic [AW-1:0] acc,
                              input logic [AW-1:0] thr, input logic rdy);
        ent_t e;
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (m_after == 2) begin
            e.d = acc; e.a = (acc >= thr); e.idx = m_idx;
            m_idx = (m_idx + 1) % (1 << IW);
            if (q.size() < 2) q.push_back(e);
            else m_drop = 1'b1;
        end
        if (nd && m_after != 0) m_seq = 1'b1;
        if (m_after == 2) m_after = 0;
        else if (m_after == 1) m_after = 2;
        else if (nd) begin
            m_cnt++;
            if (m_cnt == AC) begin
                m_cnt = 0;
                m_after = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("outValid", outValid, q.size() > 0);
        check_eq("accClear", accClear, m_after == 2);
        check_eq("dropErr", dropErr, m_drop);
        check_eq("seqErr", seqErr, m_seq);
        if (q.size() > 0) begin
            check_eq("outData", outData, q[0].d);
            check_eq("outAbove", outAbove, q[0].a);
            check_eq("outIdx", outIdx, q[0].idx);
        end
    endtask

    task automatic check_reset_zero();
        check_eq("rst_outValid", outValid, 0);
        check_eq("rst_outData", outData, 0);
        check_eq("rst_outAbove", outAbove, 0);
        check_eq("rst_outIdx", outIdx, 0);
        check_eq("rst_accClear", accClear, 0);
        check_eq("rst_dropErr", dropErr, 0);
        check_eq("rst_seqErr", seqErr, 0);
    endtask

    task automatic cycle(input logic nd, input logic [AW-1:0] acc,
                         input logic [AW-1:0] thr, input logic rdy);
        newData = nd; AccResult = acc; threshold = thr; outReady = rdy;
        @(posedge clk);
        model_step(nd, acc, thr, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_vals(output logic [AW-1:0] acc, output logic [AW-1:0] thr);
        acc = AW'($urandom);
        case ($urandom_range(0, 3))
            0: thr = AW'($urandom);
            1: thr = acc;
            2: thr = acc + 1'b1;
            default: thr = acc - 1'b1;
        endcase
    endtask

    // 0: ready; 1: stalled; 2: ready only in capture; 3: newData stuck high; 4: free random
    task automatic run_mode(input int unsigned mode, input int unsigned n);
        logic [AW-1:0] acc, thr;
        logic nd, rdy;
        for (int unsigned i = 0; i < n; i++) begin
            rand_vals(acc, thr);
            nd  = (m_after == 0) && ($urandom_range(0, 1) == 1);
            rdy = 1'b1;
            case (mode)
                1: rdy = 1'b0;
                2: rdy = (m_after == 2);
                3: begin nd = 1'b1; rdy = ($urandom_range(0, 1) == 1); end
                4: begin nd = ($urandom_range(0, 1) == 1); rdy = ($urandom_range(0, 2) != 0); end
                default: ;
            endcase
            cycle(nd, acc, thr, rdy);
        end
    endtask

    task automatic do_reset();
        newData = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_zero();
        model_reset();
        @(negedge clk);
        check_reset_zero();
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_zero();
        reset = 1'b1;

        // Four strobes of 100 vs 50, then a 49 window and a 50 window.
        repeat (4) cycle(1'b1, AW'(100), AW'(50), 1'b1);
        repeat (4) cycle(1'b0, AW'(100), AW'(50), 1'b1);
        repeat (4) cycle(1'b1, AW'(49), AW'(50), 1'b1);
        repeat (4) cycle(1'b0, AW'(49), AW'(50), 1'b1);
        repeat (4) cycle(1'b1, AW'(50), AW'(50), 1'b1);
        repeat (4) cycle(1'b0, AW'(50), AW'(50), 1'b1);

        run_mode(0, 60);
        run_mode(1, 50);
        run_mode(0, 30);

        do_reset();
        run_mode(1, 25);
        run_mode(2, 60);
        run_mode(3, 40);

        // Reset partway through a window.
        for (int unsigned i = 0; i < 50 && !(m_after == 0 && m_cnt == 2); i++) run_mode(0, 1);
        check_eq("reach_mid", m_cnt, 2);
        do_reset();
        run_mode(0, 200);
        run_mode(4, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/mac_result_collector.md
MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

Interface
REQ-001 Parameter: bitwidthAccRes, default 25, width of the MAC accumulated result.
REQ-002 Parameter: AccCycles, default 400, number of newData strobes per accumulation window.
REQ-003 Parameter: bitwidthIdx, default 16, width of the window index.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: newData  input  1  strobe, same signal that drives the MAC; one product accepted per high cycle.
REQ-007 Port: AccResult  input  bitwidthAccRes  accumulated result from the upstream MAC.
REQ-008 Port: threshold  input  bitwidthAccRes  unsigned compare value, sampled at capture.
REQ-009 Port: outReady  input  1  downstream ready.
REQ-010 Port: accClear  output  1  one-cycle pulse clearing the MAC accumulator.
REQ-011 Port: outValid  output  1  result available.
REQ-012 Port: outData  output  bitwidthAccRes  captured window result.
REQ-013 Port: outAbove  output  1  captured AccResult >= threshold.
REQ-014 Port: outIdx  output  bitwidthIdx  window number of the presented result.
REQ-015 Port: dropErr  output  1  sticky: a result was lost because the output buffer was full.
REQ-016 Port: seqErr  output  1  sticky: newData arrived outside ACCUM.

Function
REQ-017 FSM states ACCUM, SETTLE, CAPTURE; leaves reset in ACCUM.
REQ-018 ACCUM: sample counter (width clog2(AccCycles)) increments on each newData; on newData with counter = AccCycles-1, counter returns to 0 and FSM enters SETTLE.
REQ-019 SETTLE: one cycle allowing the MAC to register the last product; unconditional transition to CAPTURE.
REQ-020 CAPTURE: AccResult, (AccResult >= threshold) and current window index written as one entry into the output buffer; accClear high this cycle only; window index increments (wraps 2^bitwidthIdx-1 -> 0); FSM returns to ACCUM.
REQ-021 Window-start to outValid latency: outValid rises the cycle after CAPTURE when the buffer was empty.
REQ-022 Output buffer is 2 entries, FIFO order; transfer occurs when outValid and outReady both high on a clock edge.
REQ-023 outData/outAbove/outIdx stable while outValid high and outReady low.
REQ-024 Capture with buffer full and no same-cycle pop: entry discarded, dropErr set; window index still increments.
REQ-025 Capture with buffer full and same-cycle pop: both take effect, no drop.
REQ-026 newData in SETTLE or CAPTURE: ignored by counter, seqErr set.
REQ-027 Comparison unsigned, full bitwidthAccRes width; no truncation of AccResult.
REQ-028 dropErr and seqErr clear only on reset.

Reset
REQ-029 reset low asynchronously forces: FSM ACCUM, counter 0, window index 0, buffer empty, outValid 0, outData 0, outAbove 0, outIdx 0, accClear 0, dropErr 0, seqErr 0.
REQ-030 reset mid-window discards partial count and buffered results; the MAC is cleared by its own reset, not by accClear.
REQ-031 Reset release synchronised externally; first newData after release counts as sample 0.

Structure
REQ-032 State encoding and default widths (bitwidthAccRes, bitwidthIdx) reside in the shared MAC constants package/include.
REQ-033 Output buffer is a sub-module ResultFifo2 (2-entry valid/ready FIFO, parameterised width); FSM, counter and compare stay in the top.

Verification
REQ-034 AccCycles=4, 4 newData strobes, AccResult=100, threshold=50, outReady=1 -> accClear one pulse 2 cycles after 4th strobe; outValid next cycle with outData=100, outAbove=1, outIdx=0.
REQ-035 AccResult=49, threshold=50, then AccResult=50 next window -> outAbove 0 then 1; outIdx 0 then 1.
REQ-036 outReady=0 for 3 windows -> first two results held in order, third dropped, dropErr=1; outIdx of held entries 0,1; next accepted window has outIdx 3.
REQ-037 Buffer full, outReady pulsed exactly in CAPTURE cycle -> no drop, dropErr=0, outputs in order.
REQ-038 newData held high continuously -> strobes in SETTLE/CAPTURE set seqErr=1; window boundaries every 4 counted strobes.
REQ-039 reset low after 2 of 4 strobes -> all outputs 0 immediately (asynchronously); after release, next window needs 4 fresh strobes, outIdx=0.
